apb_master: RTL

- APB requester that drives the APB slave port of the FIFO block (FIFO write at PADDR=1, read at PADDR=2); the other end of the existing slave interface.
- Accepts one command at a time on a valid/ready request channel and runs the APB SETUP then ACCESS phases.
- Returns PRDATA, PSLVERR and a watchdog timeout flag on a valid/ready response channel.
- Sits between the test/control logic and the FIFO slave, and replaces hand-driven PSEL/PENABLE sequencing.

---
 rtl/apb_pkg.sv | 33 +++
 rtl/apb_watchdog.sv | 34 +++
 rtl/apb_master.sv | 129 ++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester and its users.
package apb_pkg;

    // Default widths used by the command/response record types
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Register map of the FIFO slave this requester talks to
    localparam int unsigned ADDR_FIFO_WR = 1;
    localparam int unsigned ADDR_FIFO_RD = 2;

    // Requester FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // One command as presented on the request channel
    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    // One response as presented on the response channel
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase watchdog: counts wait-state cycles and flags the cycle that
// reaches TIMEOUT_CYC. TIMEOUT_CYC = 0 disables expiry entirely.
module apb_watchdog #(
    parameter int  TIMEOUT_CYC = 16,
    localparam int CNT_W       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;

    assign count_inc = count + CNT_W'(1);

    // Expiry fires on the wait-state edge that would bring the count to the
    // limit, so the abort happens after exactly TIMEOUT_CYC ACCESS cycles.
    assign expire = (TIMEOUT_CYC != 0) && inc && (count_inc == CNT_W'(TIMEOUT_CYC));

    // Saturating wait-state counter, cleared when a new transfer starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_W'(TIMEOUT_CYC))) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB requester: takes one command at a time from a valid/ready channel,
// runs SETUP/ACCESS on the bus and returns the result on a one-entry
// valid/ready response channel, with an optional ACCESS watchdog.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    // request channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    // APB bus
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PSLVERR
);

    apb_state_e state;
    logic       accept;
    logic       wd_inc;
    logic       wd_expire;

    assign accept = (state == IDLE) && cmd_valid && cmd_ready;
    assign wd_inc = (state == ACCESS) && !PREADY;
    assign busy   = (state != IDLE);

    apb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (PCLK),
        .rst_n  (PRESET),
        .clr    (accept),
        .inc    (wd_inc),
        .expire (wd_expire)
    );

    // Transfer FSM with registered bus, handshake and response outputs
    always_ff @(posedge PCLK or negedge PRESET) begin
        // NOTE: every register here, data included, is cleared by the async
        // reset so an aborted transfer leaves nothing stale on the bus.
        if (!PRESET) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PADDR       <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; the drain below may
            // be overridden later in the same block by a new completion.
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        PADDR     <= cmd_addr;
                        PWRITE    <= cmd_write;
                        PWDATA    <= cmd_wdata;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end else begin
                        // Ready only once the response slot is (or becomes) empty
                        cmd_ready <= !(rsp_valid && !rsp_ready);
                    end
                end

                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= IDLE;
                    end else if (wd_expire) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
